// File: rtl/gf_pkg.sv
// ---------------------------------------------------------------------------
// gf_pkg -- shared definitions for the Galois-field library.
//   GF_N_DEFAULT     default field degree m of GF(2^m)
//   AES_POLY         x^8 + x^4 + x^3 + x + 1, the usual GF(2^8) modulus
//   SQ_W / sq_width  width of an unreduced square (2N-1 bits)
//   gf_sqrt_state_t  state encoding of the iterative square-root unit
// ---------------------------------------------------------------------------
package gf_pkg;

  localparam int         GF_N_DEFAULT = 8;
  localparam logic [8:0] AES_POLY     = 9'h11B;
  localparam int         SQ_W         = 2 * GF_N_DEFAULT - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gf_sqrt_state_t;

  // Width of the unreduced square of an n-bit field element.
  function automatic int sq_width(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/gf_sqrt_iter_if.sv
// ---------------------------------------------------------------------------
// gf_sqrt_iter_if -- operand/result handshake bundle of the square-root unit.
//   in_valid/in_ready/in_data/prim   operand channel (upstream -> unit)
//   out_valid/out_ready/out_data     result channel  (unit -> downstream)
//   master: the side that offers operands and consumes results
//   slave : the square-root unit itself
// ---------------------------------------------------------------------------
interface gf_sqrt_iter_if #(parameter int N = 8) ();

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [N:0]   prim;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;

  modport master (
    output in_valid, in_data, prim, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, prim, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/gf_sq_reduce.sv
// ---------------------------------------------------------------------------
// gf_sq_reduce -- combinational GF(2^N) squaring: a^2 mod prim.
//   a_i     field element, polynomial basis (bit i = coeff of x^i)
//   prim_i  modulus polynomial, bit N expected to be 1
//   sq_o    a^2 reduced modulo prim
// Squaring in characteristic 2 has no cross terms, so the product is just the
// input bits spread to even positions; the high half is then folded down.
// ---------------------------------------------------------------------------
module gf_sq_reduce
  import gf_pkg::*;
#(
  parameter int N = GF_N_DEFAULT
) (
  input  logic [N-1:0] a_i,
  input  logic [N:0]   prim_i,
  output logic [N-1:0] sq_o
);

  localparam int W = sq_width(N);

  logic [W-1:0] prod_s;

  // Spread a into even bit positions, then cancel bits 2N-2..N from the top
  // down by XORing prim shifted so its MSB sits on the bit being cleared.
  always_comb begin
    prod_s = '0;
    for (int i = 0; i < N; i++) begin
      prod_s[2*i] = a_i[i];
    end
    for (int j = W - 1; j >= N; j--) begin
      if (prod_s[j]) begin
        prod_s = prod_s ^ (W'(prim_i) << (j - N));
      end else begin
        prod_s = prod_s;
      end
    end
  end

  assign sq_o = prod_s[N-1:0];

endmodule

// File: rtl/gf_sqrt_iter.sv
// ---------------------------------------------------------------------------
// gf_sqrt_iter -- iterative GF(2^N) square root, sqrt(a) = a^(2^(N-1)).
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    gf_sqrt_iter_if slave: operand (in_valid/in_ready/in_data/prim)
//          and result (out_valid/out_ready/out_data) handshakes
// An accepted operand is squared N-1 times, one squaring per clock, modulo
// the prim captured at accept. The result is held until out_ready; a new
// operand is only taken in IDLE (no overlap with RUN or DONE).
// ---------------------------------------------------------------------------
module gf_sqrt_iter
  import gf_pkg::*;
#(
  parameter int N = GF_N_DEFAULT
) (
  input logic          clk,
  input logic          rst_n,
  gf_sqrt_iter_if.slave bus
);

  localparam int              CW   = $clog2(N);
  localparam logic [CW-1:0]   LAST = CW'(N - 2);

  gf_sqrt_state_t state_q, state_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [N:0]     prim_q, prim_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   out_q, out_d;
  logic           in_ready_q, in_ready_d;
  logic [N-1:0]   sq_s;

  gf_sq_reduce #(.N(N)) u_sq (
    .a_i    (acc_q),
    .prim_i (prim_q),
    .sq_o   (sq_s)
  );

  // Next-state and datapath control; outputs are registered from the _d values.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    prim_d      = prim_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          acc_d   = bus.in_data;
          prim_d  = bus.prim;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        acc_d = sq_s;
        cnt_d = cnt_q + CW'(1);
        // The last squaring lands directly in the output register so
        // out_valid rises on the same edge as the final squaring.
        if (cnt_q == LAST) begin
          out_valid_d = 1'b1;
          out_d       = sq_s;
          state_d     = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_d       = '0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        out_d       = '0;
        state_d     = IDLE;
      end
    endcase
    // Registered ready tracks the state being entered, so it is high
    // exactly while the unit sits in IDLE.
    in_ready_d = (state_d == IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      prim_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      prim_q      <= prim_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q;

endmodule

// File: tb/tb_gf_sqrt_iter.sv
// ---------------------------------------------------------------------------
// tb_gf_sqrt_iter -- scoreboard bench for gf_sqrt_iter (N=8 and N=4 units).
// Stimulus pushes the expected result of each accepted operand into a queue;
// per-instance monitors pop and compare whenever a result is handed over.
// ---------------------------------------------------------------------------
module tb_gf_sqrt_iter;
  import gf_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gf_sqrt_iter_if #(.N(8)) bus8 ();
  gf_sqrt_iter_if #(.N(4)) bus4 ();

  gf_sqrt_iter #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  gf_sqrt_iter #(.N(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  // Squares the N=8 result so it can be compared with the original operand.
  logic [7:0] chk8_s;
  gf_sq_reduce #(.N(8)) u_chk8 (.a_i(bus8.out_data), .prim_i(AES_POLY), .sq_o(chk8_s));
  logic [3:0] chk4_s;
  gf_sq_reduce #(.N(4)) u_chk4 (.a_i(4'h5), .prim_i(5'h13), .sq_o(chk4_s));

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  exp;
    int unsigned acc_cyc;
  } txn_t;

  txn_t        q8[$];
  txn_t        q4[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned last_acc8 = 0;
  bit          have_prev8 = 1'b0;
  bit          exh_mode = 1'b0;
  bit [255:0]  seen;
  logic [7:0]  inv8 [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Shift-and-add field multiply, independent of the spread/reduce datapath.
  function automatic logic [7:0] gmul8(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] b;
    logic [7:0] r;
    r = 8'h00;
    b = {1'b0, x};
    for (int i = 0; i < 8; i++) begin
      if (y[i]) r = r ^ b[7:0];
      b = b << 1;
      if (b[8]) b = b ^ 9'h11B;
    end
    return r;
  endfunction

  // N=8 monitor: result, latency, hold under backpressure, pulse end.
  logic       pv8 = 1'b0;
  logic       phs8 = 1'b0;
  logic [7:0] pout8 = 8'h00;
  always @(negedge clk) begin
    logic hs;
    txn_t t;
    if (!rst_n) begin
      pv8  <= 1'b0;
      phs8 <= 1'b0;
    end else begin
      hs = bus8.out_valid && bus8.out_ready;
      if (phs8) begin
        check("n8_pulse_end", bus8.out_valid, 1'b0);
        check("n8_ready_after", bus8.in_ready, 1'b1);
      end else if (pv8) begin
        check("n8_valid_held", bus8.out_valid, 1'b1);
        check("n8_out_held", bus8.out_data, pout8);
      end
      if (!bus8.out_valid) check("n8_out_zero", bus8.out_data, 8'h00);
      else                 check("n8_busy_ready", bus8.in_ready, 1'b0);
      if (bus8.out_valid && !pv8) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL n8_spurious: got out_valid=1, expected no result pending");
        end else begin
          check("n8_latency", cyc - q8[0].acc_cyc, 32'd7);
        end
      end
      if (hs && q8.size() != 0) begin
        t = q8.pop_front();
        check("n8_result", bus8.out_data, t.exp);
        if (exh_mode) begin
          check("n8_square_back", chk8_s, t.a);
          seen[bus8.out_data] = 1'b1;
        end
      end
      pv8   <= bus8.out_valid;
      phs8  <= hs;
      pout8 <= bus8.out_data;
    end
  end

  // N=4 monitor: latency and result.
  logic pv4 = 1'b0;
  always @(negedge clk) begin
    txn_t t;
    if (!rst_n) begin
      pv4 <= 1'b0;
    end else begin
      if (bus4.out_valid && !pv4 && q4.size() != 0)
        check("n4_latency", cyc - q4[0].acc_cyc, 32'd3);
      if (bus4.out_valid && bus4.out_ready) begin
        if (q4.size() == 0) begin
          checks++; errors++;
          $display("FAIL n4_spurious: got out_valid=1, expected no result pending");
        end else begin
          t = q4.pop_front();
          check("n4_result", {28'd0, bus4.out_data}, {24'd0, t.exp});
        end
      end
      pv4 <= bus4.out_valid;
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] e);
    int   n;
    txn_t t;
    n = 0;
    bus8.in_data  = a;
    bus8.prim     = 9'h11B;
    bus8.in_valid = 1'b1;
    while (!bus8.in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      checks++; errors++;
      $display("FAIL n8_accept_timeout: got in_ready=0, expected 1 within 60 cycles");
      bus8.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus8.in_valid = 1'b0;
      t.a = a; t.exp = e; t.acc_cyc = cyc;
      if (have_prev8) check("n8_accept_gap", (cyc - last_acc8) >= 9, 1'b1);
      have_prev8 = 1'b1;
      last_acc8  = cyc;
      q8.push_back(t);
    end
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] e);
    int   n;
    txn_t t;
    n = 0;
    bus4.in_data  = a;
    bus4.prim     = 5'h13;
    bus4.in_valid = 1'b1;
    while (!bus4.in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      checks++; errors++;
      $display("FAIL n4_accept_timeout: got in_ready=0, expected 1 within 60 cycles");
      bus4.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus4.in_valid = 1'b0;
      t.a = {4'h0, a}; t.exp = {4'h0, e}; t.acc_cyc = cyc;
      q4.push_back(t);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q8.size() != 0 || q4.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d/%0d pending, expected 0", q8.size(), q4.size());
      q8.delete();
      q4.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    // Inverse of the squaring map gives the expected square roots.
    for (int x = 0; x < 256; x++) inv8[gmul8(8'(x), 8'(x))] = 8'(x);

    bus8.in_valid = 1'b0; bus8.in_data = 8'h00; bus8.prim = 9'h11B; bus8.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.in_data = 4'h0;  bus4.prim = 5'h13;  bus4.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus8.out_valid, 1'b0);
    check("rst_out", bus8.out_data, 8'h00);
    check("rst_in_ready", bus8.in_ready, 1'b0);
    check("rst4_out_valid", bus4.out_valid, 1'b0);
    rst_n = 1'b1;

    // Basic root, then three back-to-back operands.
    send8(8'h02, 8'hFA);
    drain();
    send8(8'h04, 8'h02);
    send8(8'h00, 8'h00);
    send8(8'h01, 8'h01);
    drain();

    // Small field and its squaring datapath.
    send4(4'h2, 4'h5);
    drain();
    check("n4_square_of_5", chk4_s, 4'h2);

    // Backpressure with changing in/prim while busy.
    bus8.out_ready = 1'b0;
    send8(8'h02, 8'hFA);
    for (int i = 0; i < 27; i++) begin
      @(posedge clk);
      #1;
      bus8.in_valid = 1'b1;
      bus8.in_data  = 8'($urandom);
      bus8.prim     = 9'($urandom);
    end
    bus8.in_valid  = 1'b0;
    bus8.prim      = 9'h11B;
    bus8.out_ready = 1'b1;
    drain();

    // Reset while running at cnt=3; the partial result is discarded.
    send8(8'h04, 8'h02);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    q8.delete();
    have_prev8 = 1'b0;
    check("midrst_out_valid", bus8.out_valid, 1'b0);
    check("midrst_out", bus8.out_data, 8'h00);
    check("midrst_in_ready", bus8.in_ready, 1'b0);
    rst_n = 1'b1;
    send8(8'h04, 8'h02);
    drain();

    // Every element: result matches the inverse table and squares back.
    exh_mode = 1'b1;
    seen = '0;
    for (int a = 0; a < 256; a++) send8(8'(a), inv8[a]);
    drain();
    exh_mode = 1'b0;
    check("bijection", $countones(seen), 32'd256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
